// File: rtl/hue_pattern_gen.sv
// LED pattern source: one GRB pixel per LED per frame from a 1536-step hue wheel, brightness-scaled.
// Latency >=3 cycles per pixel (CALC, SCALE, PRESENT); pix_addr/pix_color held stable while pix_ready is low.
module hue_pattern_gen #(
    parameter int NUM_LEDS       = 150,
    parameter int ADDR_W         = 16,
    parameter int HUE_STEP_LED   = 17,
    parameter int HUE_STEP_FRAME = 17,
    parameter int FRAME_DIV      = 2**20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [7:0]        brightness,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [23:0]       pix_color,
    output logic              frame_done
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_CALC, S_SCALE, S_PRESENT, S_DONE, S_WAIT
    } state_t;

    localparam logic [1:0] M_RAINBOW = 2'd0;
    localparam logic [1:0] M_CHASE   = 2'd2;
    localparam logic [1:0] M_OFF     = 2'd3;

    state_t      r_state;
    logic [1:0]  r_mode;
    logic [10:0] r_start_hue;
    logic [10:0] r_hue;
    logic [ADDR_W-1:0] r_chase;
    logic [31:0] r_wait;
    logic [7:0]  r_r, r_g, r_b;

    logic [10:0] w_calc_hue;
    logic [7:0]  w_f, w_nf;
    logic [7:0]  w_r, w_g, w_b;
    logic        w_dark;
    logic [15:0] w_bscale;
    logic [7:0]  w_sr, w_sg, w_sb;

    // Hue sums stay below 3072, so one conditional subtract brings them back into 0..1535.
    function automatic logic [10:0] hue_add(input logic [10:0] a, input logic [10:0] b);
        logic [11:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 12'd1536)
            s = s - 12'd1536;
        return s[10:0];
    endfunction

    assign w_calc_hue = (r_mode == M_RAINBOW) ? r_hue : r_start_hue;
    assign w_f        = w_calc_hue[7:0];
    assign w_nf       = ~w_calc_hue[7:0];
    assign w_dark     = (r_mode == M_OFF) || ((r_mode == M_CHASE) && (pix_addr != r_chase));

    always_comb begin
        w_r = 8'd0;
        w_g = 8'd0;
        w_b = 8'd0;
        case (w_calc_hue[10:8])
            3'd0: begin w_r = 8'hFF; w_g = w_f;   w_b = 8'h00; end
            3'd1: begin w_r = w_nf;  w_g = 8'hFF; w_b = 8'h00; end
            3'd2: begin w_r = 8'h00; w_g = 8'hFF; w_b = w_f;   end
            3'd3: begin w_r = 8'h00; w_g = w_nf;  w_b = 8'hFF; end
            3'd4: begin w_r = w_f;   w_g = 8'h00; w_b = 8'hFF; end
            3'd5: begin w_r = 8'hFF; w_g = 8'h00; w_b = w_nf;  end
            default: begin w_r = 8'd0; w_g = 8'd0; w_b = 8'd0; end
        endcase
    end

    assign w_bscale = {8'd0, brightness} + 16'd1;
    assign w_sr     = 8'((16'(r_r) * w_bscale) >> 8);
    assign w_sg     = 8'((16'(r_g) * w_bscale) >> 8);
    assign w_sb     = 8'((16'(r_b) * w_bscale) >> 8);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode      <= 2'd0;
            r_start_hue <= 11'd0;
            r_hue       <= 11'd0;
            r_chase     <= '0;
            r_wait      <= 32'd0;
            r_r         <= 8'd0;
            r_g         <= 8'd0;
            r_b         <= 8'd0;
            pix_valid   <= 1'b0;
            pix_addr    <= '0;
            pix_color   <= 24'd0;
            frame_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable)
                        r_state <= S_START;
                end
                S_START: begin
                    r_mode   <= mode;
                    r_hue    <= r_start_hue;
                    pix_addr <= '0;
                    r_state  <= S_CALC;
                end
                S_CALC: begin
                    r_r     <= w_dark ? 8'd0 : w_r;
                    r_g     <= w_dark ? 8'd0 : w_g;
                    r_b     <= w_dark ? 8'd0 : w_b;
                    r_state <= S_SCALE;
                end
                S_SCALE: begin
                    pix_color <= {w_sg, w_sr, w_sb};
                    pix_valid <= 1'b1;
                    r_state   <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        if (pix_addr == ADDR_W'(NUM_LEDS - 1)) begin
                            frame_done <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            pix_addr <= pix_addr + ADDR_W'(1);
                            r_hue    <= hue_add(r_hue, 11'(HUE_STEP_LED));
                            r_state  <= S_CALC;
                        end
                    end
                end
                S_DONE: begin
                    frame_done  <= 1'b0;
                    r_start_hue <= hue_add(r_start_hue, 11'(HUE_STEP_FRAME));
                    r_chase     <= (r_chase == ADDR_W'(NUM_LEDS - 1)) ? '0 : r_chase + ADDR_W'(1);
                    r_wait      <= 32'd0;
                    r_state     <= (FRAME_DIV == 0) ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait == 32'(FRAME_DIV - 1))
                        r_state <= S_IDLE;
                    else
                        r_wait <= r_wait + 32'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hue_pattern_gen.sv
// Directed frame sequence with random brightness/stalls, checked against a hue-wheel reference model.
module tb_hue_pattern_gen;
    localparam int N   = 4;
    localparam int HSL = 256;
    localparam int HSF = 1000;
    localparam int FD  = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  mode;
    logic [7:0]  brightness;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_addr;
    logic [23:0] pix_color;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    int m_sh     = 0;
    int m_chase  = 0;

    hue_pattern_gen #(
        .NUM_LEDS(N), .ADDR_W(16), .HUE_STEP_LED(HSL), .HUE_STEP_FRAME(HSF), .FRAME_DIV(FD)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .brightness(brightness),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_addr(pix_addr),
        .pix_color(pix_color), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_pix(input int fm, input int addr, input int bri);
        int h, f, r, g, b;
        if (fm == 3 || (fm == 2 && addr != m_chase))
            return 24'h000000;
        h = (fm == 0) ? (m_sh + addr * HSL) % 1536 : m_sh;
        f = h % 256;
        case (h / 256)
            0: begin r = 255;     g = f;       b = 0;       end
            1: begin r = 255 - f; g = 255;     b = 0;       end
            2: begin r = 0;       g = 255;     b = f;       end
            3: begin r = 0;       g = 255 - f; b = 255;     end
            4: begin r = f;       g = 0;       b = 255;     end
            default: begin r = 255; g = 0;     b = 255 - f; end
        endcase
        r = r * (bri + 1) / 256;
        g = g * (bri + 1) / 256;
        b = b * (bri + 1) / 256;
        return {8'(g), 8'(r), 8'(b)};
    endfunction

    // fixed_b < 0: new random brightness per pixel; stall_max < 0: exactly -stall_max stall cycles.
    task automatic run_frame(input int fm, input int fixed_b, input bit hold, input int stall_max,
                             input bit chg_mode, input bit drop_en, input int rst_at);
        int t, bri, bri_next, stall;
        logic [23:0] exp;
        mode      = 2'(fm);
        enable    = 1'b1;
        pix_ready = hold;
        bri       = (fixed_b < 0) ? int'($urandom_range(255)) : fixed_b;
        brightness = 8'(bri);
        bri_next  = bri;
        for (int a = 0; a < N; a++) begin
            t = 0;
            while (pix_valid !== 1'b1 && t < 80) begin
                @(negedge clk);
                t++;
            end
            chk("pix_valid_rise", 32'(pix_valid), 32'd1);
            if (pix_valid !== 1'b1)
                return;
            exp = exp_pix(fm, a, bri);
            chk("pix_addr", 32'(pix_addr), 32'(a));
            chk("pix_color", 32'(pix_color), 32'(exp));
            chk("frame_done_low", 32'(frame_done), 32'd0);
            if (rst_at == a) begin
                #1 rst = 1'b1;
                #1;
                chk("rst_valid", 32'(pix_valid), 32'd0);
                chk("rst_addr", 32'(pix_addr), 32'd0);
                chk("rst_color", 32'(pix_color), 32'd0);
                @(negedge clk);
                rst       = 1'b0;
                pix_ready = 1'b0;
                m_sh      = 0;
                m_chase   = 0;
                return;
            end
            stall = hold ? 0 : (stall_max < 0 ? -stall_max : int'($urandom_range(stall_max)));
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk("stall_valid", 32'(pix_valid), 32'd1);
                chk("stall_addr", 32'(pix_addr), 32'(a));
                chk("stall_color", 32'(pix_color), 32'(exp));
            end
            pix_ready = 1'b1;
            if (fixed_b < 0) begin
                bri_next   = $urandom_range(255);
                brightness = 8'(bri_next);
            end
            if (a == 0 && chg_mode)
                mode = 2'(fm) ^ 2'(1 + $urandom_range(2));
            if (a == 0 && drop_en)
                enable = 1'b0;
            @(posedge clk);
            @(negedge clk);
            pix_ready = hold;
            chk("valid_drop", 32'(pix_valid), 32'd0);
            chk("frame_done_pulse", 32'(frame_done), (a == N - 1) ? 32'd1 : 32'd0);
            bri = bri_next;
        end
        @(negedge clk);
        chk("frame_done_end", 32'(frame_done), 32'd0);
        m_sh    = (m_sh + HSF) % 1536;
        m_chase = (m_chase + 1) % N;
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        mode       = 2'd0;
        brightness = 8'd255;
        pix_ready  = 1'b0;
        #2;
        chk("reset_valid", 32'(pix_valid), 32'd0);
        chk("reset_addr", 32'(pix_addr), 32'd0);
        chk("reset_color", 32'(pix_color), 32'd0);
        chk("reset_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("idle_disabled", 32'(pix_valid), 32'd0);
        end

        run_frame(0, 255, 1'b1, 0, 1'b0, 1'b0, -1);
        run_frame(1, 127, 1'b0, 3, 1'b0, 1'b0, -1);
        run_frame(1, 0,   1'b0, 2, 1'b0, 1'b0, -1);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        m_sh    = 0;
        m_chase = 0;
        run_frame(1, 127, 1'b0, 2, 1'b1, 1'b0, -1);

        for (int k = 0; k < 5; k++)
            run_frame(2, -1, 1'b0, 3, k[0], 1'b0, -1);
        run_frame(0, -1, 1'b0, -10, 1'b0, 1'b0, -1);
        run_frame(3, 200, 1'b1, 0, 1'b1, 1'b0, -1);

        run_frame(0, -1, 1'b0, 2, 1'b0, 1'b1, -1);
        repeat (30) begin
            @(negedge clk);
            chk("hold_idle", 32'(pix_valid), 32'd0);
        end

        run_frame(0, 255, 1'b1, 0, 1'b0, 1'b0, 2);
        run_frame(0, 255, 1'b1, 0, 1'b0, 1'b0, -1);

        for (int k = 0; k < 6; k++)
            run_frame(int'($urandom_range(3)), -1, 1'($urandom_range(1)), 3,
                      1'($urandom_range(1)), 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
